// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// Round-robin front end that shares one pipelined spu_op unit between NUM_REQ requesters.
// The requester ID rides a valid/ID shadow pipe so each result comes back tagged with its owner.
module elixirchip_es1_spu_op_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int LATENCY   = 3,
  parameter  int DATA_BITS = 8,
  localparam int ID_BITS   = $clog2(NUM_REQ),
  localparam int CNT_BITS  = $clog2(LATENCY + 2)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cke,
  input  logic [NUM_REQ-1:0]             s_req_valid,
  output logic [NUM_REQ-1:0]             s_req_ready,
  input  logic [NUM_REQ*DATA_BITS-1:0]   s_req_data0,
  input  logic [NUM_REQ*DATA_BITS-1:0]   s_req_data1,
  input  logic [NUM_REQ-1:0]             s_req_clear,
  output logic                           op_cke,
  output logic [DATA_BITS-1:0]           op_data0,
  output logic [DATA_BITS-1:0]           op_data1,
  output logic                           op_clear,
  output logic                           op_valid,
  input  logic [DATA_BITS-1:0]           op_m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_BITS-1:0]           m_data,
  output logic [ID_BITS-1:0]             m_id,
  output logic                           busy,
  output logic [CNT_BITS-1:0]            inflight
);

  logic                        found;
  logic                        accept;
  logic                        retire;
  logic [ID_BITS-1:0]          rr_ptr;
  logic [ID_BITS-1:0]          winner;
  logic [ID_BITS-1:0]          idx;
  int                          pos;
  logic [DATA_BITS-1:0]        d0_arr [NUM_REQ];
  logic [DATA_BITS-1:0]        d1_arr [NUM_REQ];
  logic [LATENCY-1:0]          vp;
  logic [LATENCY*ID_BITS-1:0]  id_pipe;
  logic [CNT_BITS-1:0]         count;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign d0_arr[g] = s_req_data0[g*DATA_BITS +: DATA_BITS];
    assign d1_arr[g] = s_req_data1[g*DATA_BITS +: DATA_BITS];
  end

  // A result waiting at the tail with no taker freezes the op unit and the shadow pipe together.
  assign op_cke = cke && !(m_valid && !m_ready);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = 0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = ID_BITS'(pos);
      if (!found && s_req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign accept   = found && op_cke && reset_n;
  assign retire   = m_valid && m_ready && cke;
  assign op_valid = accept;
  assign op_data0 = found ? d0_arr[winner] : '0;
  assign op_data1 = found ? d1_arr[winner] : '0;
  assign op_clear = found ? s_req_clear[winner] : 1'b0;

  always_comb begin
    s_req_ready = '0;
    if (found && reset_n) s_req_ready[winner] = op_cke;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (winner == ID_BITS'(NUM_REQ - 1)) ? '0 : winner + ID_BITS'(1);
    end
  end

  if (LATENCY == 1) begin : g_pipe_single
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vp      <= '0;
        id_pipe <= '0;
      end else if (op_cke) begin
        vp      <= accept;
        id_pipe <= winner;
      end
    end
  end else begin : g_pipe_multi
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vp      <= '0;
        id_pipe <= '0;
      end else if (op_cke) begin
        vp      <= {vp[LATENCY-2:0], accept};
        id_pipe <= {id_pipe[(LATENCY-1)*ID_BITS-1:0], winner};
      end
    end
  end

  assign m_valid = vp[LATENCY-1];
  assign m_id    = id_pipe[LATENCY*ID_BITS-1 -: ID_BITS];
  assign m_data  = op_m_data;

  // Accept and retire in the same cycle cancel out, so the count never exceeds LATENCY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (accept && !retire) begin
      count <= count + CNT_BITS'(1);
    end else if (!accept && retire) begin
      count <= count - CNT_BITS'(1);
    end
  end

  assign inflight = count;
  assign busy     = (count != '0);

endmodule

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
// Bench for the op arbiter: an xnor op unit stand-in plus a queue-of-results reference model.
module tb_elixirchip_es1_spu_op_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int DW   = 8;
  localparam logic [7:0] CLEAR_DATA = 8'd123;

  logic        clk, reset_n, cke;
  logic [3:0]  s_req_valid, s_req_ready, s_req_clear;
  logic [31:0] s_req_data0, s_req_data1;
  logic        op_cke, op_clear, op_valid;
  logic [7:0]  op_data0, op_data1, op_m_data, m_data;
  logic        m_valid, m_ready, busy;
  logic [1:0]  m_id;
  logic [2:0]  inflight;

  elixirchip_es1_spu_op_arbiter #(.NUM_REQ(NREQ), .LATENCY(LAT), .DATA_BITS(DW)) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_data0(s_req_data0), .s_req_data1(s_req_data1), .s_req_clear(s_req_clear),
    .op_cke(op_cke), .op_data0(op_data0), .op_data1(op_data1), .op_clear(op_clear),
    .op_valid(op_valid), .op_m_data(op_m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
    .busy(busy), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for a LATENCY-deep xnor op unit with CLEAR_DATA on clear.
  logic [7:0] op_stage [LAT];
  always @(posedge clk) begin
    if (op_cke) begin
      op_stage[0] <= op_clear ? CLEAR_DATA : ~(op_data0 ^ op_data1);
      for (int k = 1; k < LAT; k++) op_stage[k] <= op_stage[k-1];
    end
  end
  assign op_m_data = op_stage[LAT-1];

  // Reference model: results queued in acceptance order, each aged by op_cke-qualified edges.
  typedef struct { int id; int data; int age; } entry_t;
  entry_t sb[$];
  int rr;
  int n_checks, n_fail;
  bit exp_found, exp_accept, exp_op_cke, exp_m_valid;
  int exp_winner, exp_m_id, exp_m_data;
  logic [3:0] exp_ready;

  task automatic predict();
    int j;
    exp_m_valid = (sb.size() > 0) && (sb[0].age >= LAT);
    exp_m_id    = exp_m_valid ? sb[0].id : 0;
    exp_m_data  = exp_m_valid ? sb[0].data : 0;
    exp_op_cke  = cke && !(exp_m_valid && !m_ready);
    exp_found   = 1'b0;
    exp_winner  = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (rr + k) % NREQ;
      if (!exp_found && s_req_valid[j]) begin
        exp_found  = 1'b1;
        exp_winner = j;
      end
    end
    exp_accept = exp_found && exp_op_cke && reset_n;
    exp_ready  = 4'b0000;
    if (exp_accept) exp_ready[exp_winner] = 1'b1;
  endtask

  task automatic commit();
    entry_t e;
    logic [7:0] a, b;
    if (reset_n && exp_op_cke) begin
      if (exp_m_valid && m_ready) void'(sb.pop_front());
      foreach (sb[i]) sb[i].age = sb[i].age + 1;
      if (exp_accept) begin
        a = s_req_data0[exp_winner*DW +: DW];
        b = s_req_data1[exp_winner*DW +: DW];
        e.id   = exp_winner;
        e.data = s_req_clear[exp_winner] ? int'(CLEAR_DATA) : int'(8'(~(a ^ b)));
        e.age  = 1;
        sb.push_back(e);
        rr = (exp_winner + 1) % NREQ;
      end
    end
  endtask

  task automatic set_idle();
    s_req_valid = 4'h0; s_req_clear = 4'h0;
    s_req_data0 = 32'h0; s_req_data1 = 32'h0;
    m_ready = 1'b1; cke = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic clr);
    s_req_valid[i] = 1'b1;
    s_req_clear[i] = clr;
    s_req_data0[i*DW +: DW] = a;
    s_req_data1[i*DW +: DW] = b;
  endtask

  task automatic cycle_begin();
    #1;
    predict();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    s_req_valid = 4'hf;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (m_id !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_m_id: got %0d expected 0", m_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_inflight: got %0d expected 0", inflight); end
    n_checks++; if (s_req_ready !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0000", s_req_ready); end
    @(negedge clk);
    set_idle();
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int grant_seq [5];
    int retired;
    grant_seq = '{0, 1, 2, 3, 0};
    retired = 0;
    for (int n = 0; n < 12; n++) begin
      set_idle();
      if (n < 5) begin
        s_req_valid = 4'hf; s_req_data0 = $urandom; s_req_data1 = $urandom;
      end
      cycle_begin();
      if (n < 5) begin
        n_checks++;
        if (s_req_ready !== 4'(1 << grant_seq[n])) begin n_fail++; $display("[TB] FAIL rr_grant cycle %0d: got %b expected %b", n, s_req_ready, 4'(1 << grant_seq[n])); end
      end
      n_checks++; if (m_valid !== exp_m_valid) begin n_fail++; $display("[TB] FAIL rr_m_valid cycle %0d: got %b expected %b", n, m_valid, exp_m_valid); end
      if (m_valid === 1'b1 && retired < 5) begin
        n_checks++; if (m_id !== 2'(grant_seq[retired])) begin n_fail++; $display("[TB] FAIL rr_result_id #%0d: got %0d expected %0d", retired, m_id, grant_seq[retired]); end
        n_checks++; if (m_data !== 8'(exp_m_data)) begin n_fail++; $display("[TB] FAIL rr_result_data #%0d: got %h expected %h", retired, m_data, 8'(exp_m_data)); end
        retired++;
      end
      cycle_end();
    end
    n_checks++; if (retired != 5) begin n_fail++; $display("[TB] FAIL rr_retire_count: got %0d expected 5", retired); end
  endtask

  task automatic test_single();
    for (int n = 0; n < 6; n++) begin
      set_idle();
      if (n == 0) set_req(1, 8'h5a, 8'ha5, 1'b0);
      cycle_begin();
      if (n == 0) begin
        n_checks++; if (s_req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 0010", s_req_ready); end
      end
      n_checks++; if (m_valid !== (n == 3)) begin n_fail++; $display("[TB] FAIL single_m_valid after %0d edges: got %b expected %b", n, m_valid, (n == 3)); end
      n_checks++; if (busy !== (n >= 1 && n <= 3)) begin n_fail++; $display("[TB] FAIL single_busy after %0d edges: got %b expected %b", n, busy, (n >= 1 && n <= 3)); end
      n_checks++; if (inflight !== 3'(sb.size())) begin n_fail++; $display("[TB] FAIL single_inflight after %0d edges: got %0d expected %0d", n, inflight, sb.size()); end
      if (n == 3) begin
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("[TB] FAIL single_m_data: got %h expected 00", m_data); end
        n_checks++; if (m_id !== 2'd1) begin n_fail++; $display("[TB] FAIL single_m_id: got %0d expected 1", m_id); end
      end
      cycle_end();
    end
  endtask

  task automatic test_backpressure();
    int retired;
    retired = 0;
    for (int n = 0; n < 16; n++) begin
      set_idle();
      m_ready = !(n >= 3 && n <= 7);
      if (n < 8) begin
        s_req_valid = 4'hf; s_req_data0 = $urandom; s_req_data1 = $urandom;
      end
      cycle_begin();
      if (n >= 3 && n <= 7) begin
        n_checks++; if (op_cke !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_op_cke cycle %0d: got %b expected 0", n, op_cke); end
        n_checks++; if (s_req_ready !== 4'h0) begin n_fail++; $display("[TB] FAIL bp_ready cycle %0d: got %b expected 0000", n, s_req_ready); end
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_m_valid cycle %0d: got %b expected 1", n, m_valid); end
        n_checks++; if (m_id !== 2'(exp_m_id)) begin n_fail++; $display("[TB] FAIL bp_hold_id cycle %0d: got %0d expected %0d", n, m_id, exp_m_id); end
        n_checks++; if (m_data !== 8'(exp_m_data)) begin n_fail++; $display("[TB] FAIL bp_hold_data cycle %0d: got %h expected %h", n, m_data, 8'(exp_m_data)); end
        n_checks++; if (inflight !== 3'd3) begin n_fail++; $display("[TB] FAIL bp_inflight cycle %0d: got %0d expected 3", n, inflight); end
      end else begin
        n_checks++; if (s_req_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL bp_ready cycle %0d: got %b expected %b", n, s_req_ready, exp_ready); end
        n_checks++; if (m_valid !== exp_m_valid) begin n_fail++; $display("[TB] FAIL bp_m_valid cycle %0d: got %b expected %b", n, m_valid, exp_m_valid); end
        if (m_valid === 1'b1) begin
          retired++;
          n_checks++; if (m_id !== 2'(exp_m_id)) begin n_fail++; $display("[TB] FAIL bp_result_id cycle %0d: got %0d expected %0d", n, m_id, exp_m_id); end
          n_checks++; if (m_data !== 8'(exp_m_data)) begin n_fail++; $display("[TB] FAIL bp_result_data cycle %0d: got %h expected %h", n, m_data, 8'(exp_m_data)); end
        end
      end
      cycle_end();
    end
    n_checks++; if (retired != 3) begin n_fail++; $display("[TB] FAIL bp_retire_count: got %0d expected 3", retired); end
    n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("[TB] FAIL bp_drain_inflight: got %0d expected 0", inflight); end
  endtask

  task automatic test_freeze();
    int r;
    for (int n = 0; n < 12; n++) begin
      set_idle();
      cke = !(n == 3 || n == 4);
      if (n < 6) begin
        r = $urandom_range(0, 3);
        set_req(r, 8'($urandom), 8'($urandom), 1'b0);
      end
      cycle_begin();
      n_checks++; if (op_cke !== exp_op_cke) begin n_fail++; $display("[TB] FAIL frz_op_cke cycle %0d: got %b expected %b", n, op_cke, exp_op_cke); end
      n_checks++; if (s_req_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL frz_ready cycle %0d: got %b expected %b", n, s_req_ready, exp_ready); end
      n_checks++; if (m_valid !== exp_m_valid) begin n_fail++; $display("[TB] FAIL frz_m_valid cycle %0d: got %b expected %b", n, m_valid, exp_m_valid); end
      n_checks++; if (inflight !== 3'(sb.size())) begin n_fail++; $display("[TB] FAIL frz_inflight cycle %0d: got %0d expected %0d", n, inflight, sb.size()); end
      if (exp_m_valid) begin
        n_checks++; if (m_id !== 2'(exp_m_id)) begin n_fail++; $display("[TB] FAIL frz_m_id cycle %0d: got %0d expected %0d", n, m_id, exp_m_id); end
        n_checks++; if (m_data !== 8'(exp_m_data)) begin n_fail++; $display("[TB] FAIL frz_m_data cycle %0d: got %h expected %h", n, m_data, 8'(exp_m_data)); end
      end
      if (n == 3 || n == 4) begin
        n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL frz_op_valid cycle %0d: got %b expected 0", n, op_valid); end
        n_checks++; if (inflight !== 3'd3 || m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL frz_hold cycle %0d: got inflight %0d m_valid %b expected 3 1", n, inflight, m_valid); end
      end
      cycle_end();
    end
  endtask

  task automatic test_clear();
    for (int n = 0; n < 6; n++) begin
      set_idle();
      if (n == 0) set_req(2, 8'($urandom), 8'($urandom), 1'b1);
      cycle_begin();
      if (n == 0) begin
        n_checks++; if (op_clear !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_op_clear: got %b expected 1", op_clear); end
      end
      n_checks++; if (m_valid !== (n == 3)) begin n_fail++; $display("[TB] FAIL clr_m_valid after %0d edges: got %b expected %b", n, m_valid, (n == 3)); end
      if (n == 3) begin
        n_checks++; if (m_data !== CLEAR_DATA) begin n_fail++; $display("[TB] FAIL clr_m_data: got %0d expected 123", m_data); end
        n_checks++; if (m_id !== 2'd2) begin n_fail++; $display("[TB] FAIL clr_m_id: got %0d expected 2", m_id); end
      end
      cycle_end();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 408; n++) begin
      set_idle();
      if (n < 400) begin
        s_req_valid = 4'($urandom);
        s_req_data0 = $urandom;
        s_req_data1 = $urandom;
        s_req_clear = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        m_ready     = ($urandom_range(0, 3) != 0);
        cke         = ($urandom_range(0, 9) != 0);
      end
      cycle_begin();
      n_checks++; if (s_req_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rnd_ready cycle %0d: got %b expected %b", n, s_req_ready, exp_ready); end
      n_checks++; if (op_cke !== exp_op_cke) begin n_fail++; $display("[TB] FAIL rnd_op_cke cycle %0d: got %b expected %b", n, op_cke, exp_op_cke); end
      n_checks++; if (op_valid !== exp_accept) begin n_fail++; $display("[TB] FAIL rnd_op_valid cycle %0d: got %b expected %b", n, op_valid, exp_accept); end
      n_checks++; if (m_valid !== exp_m_valid) begin n_fail++; $display("[TB] FAIL rnd_m_valid cycle %0d: got %b expected %b", n, m_valid, exp_m_valid); end
      n_checks++; if (inflight !== 3'(sb.size())) begin n_fail++; $display("[TB] FAIL rnd_inflight cycle %0d: got %0d expected %0d", n, inflight, sb.size()); end
      n_checks++; if (busy !== (sb.size() != 0)) begin n_fail++; $display("[TB] FAIL rnd_busy cycle %0d: got %b expected %b", n, busy, (sb.size() != 0)); end
      if (exp_m_valid) begin
        n_checks++; if (m_id !== 2'(exp_m_id)) begin n_fail++; $display("[TB] FAIL rnd_m_id cycle %0d: got %0d expected %0d", n, m_id, exp_m_id); end
        n_checks++; if (m_data !== 8'(exp_m_data)) begin n_fail++; $display("[TB] FAIL rnd_m_data cycle %0d: got %h expected %h", n, m_data, 8'(exp_m_data)); end
      end
      if (exp_found) begin
        n_checks++;
        if (op_data0 !== s_req_data0[exp_winner*DW +: DW] || op_data1 !== s_req_data1[exp_winner*DW +: DW] || op_clear !== s_req_clear[exp_winner]) begin
          n_fail++; $display("[TB] FAIL rnd_op_fields cycle %0d: got %h %h %b expected requester %0d fields", n, op_data0, op_data1, op_clear, exp_winner);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_reset_inflight();
    for (int n = 0; n < 3; n++) begin
      set_idle();
      s_req_valid = 4'hf; s_req_data0 = $urandom; s_req_data1 = $urandom;
      cycle_begin();
      n_checks++; if (s_req_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rst_fill_ready cycle %0d: got %b expected %b", n, s_req_ready, exp_ready); end
      cycle_end();
    end
    set_idle();
    s_req_valid = 4'hf;
    m_ready = 1'b0;
    #1;
    n_checks++; if (inflight !== 3'd3 || m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre_state: got inflight %0d m_valid %b expected 3 1", inflight, m_valid); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_async_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (inflight !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_async_count: got inflight %0d busy %b expected 0 0", inflight, busy); end
    n_checks++; if (s_req_ready !== 4'h0 || m_id !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_async_outputs: got ready %b m_id %0d expected 0000 0", s_req_ready, m_id); end
    sb.delete();
    rr = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      set_idle();
      if (n == 2) set_req(3, 8'h0f, 8'h0e, 1'b0);
      cycle_begin();
      n_checks++; if (m_valid !== exp_m_valid) begin n_fail++; $display("[TB] FAIL rst_after_m_valid cycle %0d: got %b expected %b", n, m_valid, exp_m_valid); end
      n_checks++; if (inflight !== 3'(sb.size())) begin n_fail++; $display("[TB] FAIL rst_after_inflight cycle %0d: got %0d expected %0d", n, inflight, sb.size()); end
      if (n == 5) begin
        n_checks++; if (m_valid !== 1'b1 || m_id !== 2'd3 || m_data !== 8'hfe) begin n_fail++; $display("[TB] FAIL rst_new_result: got v%b id%0d data %h expected v1 id3 data fe", m_valid, m_id, m_data); end
      end
      cycle_end();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rr       = 0;
    sb.delete();
    set_idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] starting arbiter bench");
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_freeze();
    test_clear();
    test_random();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elixirchip_es1_spu_op_arbiter.md
Name: elixirchip_es1_spu_op_arbiter

Overview:
Shares one pipelined elixirchip_es1_spu_op_* unit (e.g. xnor, LATENCY cycles) between NUM_REQ requesters.
- Round-robin arbitration; accepted operands are driven into the op unit.
- The requester ID travels through a valid/ID shadow pipeline aligned to the op unit's latency.
- Each result is returned with its ID on a valid/ready port; backpressure stalls the op unit through its cke.

Parameters:
NUM_REQ, 4, number of requesters, 2..16
LATENCY, 3, op unit latency in cke-qualified cycles; must equal the attached unit's LATENCY; 1..8 (0 not supported)
DATA_BITS, 8, operand/result width
ID_BITS, $clog2(NUM_REQ), requester ID width (derived localparam)

Ports:
clk  in  1  clock, all flops rising edge
reset_n  in  1  asynchronous active-low reset
cke  in  1  global clock enable; 0 freezes the whole block
s_req_valid  in  NUM_REQ  per-requester request valid
s_req_ready  out  NUM_REQ  per-requester accept
s_req_data0  in  NUM_REQ*DATA_BITS  operand 0, requester i at [i*DATA_BITS +: DATA_BITS]
s_req_data1  in  NUM_REQ*DATA_BITS  operand 1, same packing
s_req_clear  in  NUM_REQ  per-requester clear request
op_cke  out  1  to op unit cke
op_data0  out  DATA_BITS  to op unit s_data0
op_data1  out  DATA_BITS  to op unit s_data1
op_clear  out  1  to op unit s_clear
op_valid  out  1  to op unit s_valid
op_m_data  in  DATA_BITS  from op unit m_data
m_valid  out  1  result valid
m_ready  in  1  result accept
m_data  out  DATA_BITS  result, equals op_m_data
m_id  out  ID_BITS  requester ID of the result
busy  out  1  one or more operations in flight
inflight  out  $clog2(LATENCY+2)  in-flight count

Behaviour:
Reset (async, reset_n=0):
- Valid pipe cleared, ID pipe 0, RR pointer 0, inflight 0.
- Outputs: m_valid=0, m_id=0, busy=0, s_req_ready=0.
- Reset mid-operation discards all in-flight results; none are emitted after release.

Stall:
- stall = m_valid && !m_ready.
- op_cke = cke && !stall, combinational.

Arbitration (combinational):
- Winner = first i with s_req_valid[i]=1, searching from RR pointer upward and wrapping.
- s_req_ready[winner] = op_cke. All other ready bits 0.
- accept = any valid && op_cke.
- op_valid = accept. op_data0/op_data1/op_clear = winner's fields.
- With no valid request: op_valid=0 and op_data0/op_data1/op_clear=0.

RR pointer:
- On accept: pointer <= winner+1 mod NUM_REQ.
- Otherwise: pointer holds.
- Result: a continuously requesting requester is served at most once per NUM_REQ accepts when others are waiting.

Shadow pipeline (depth LATENCY, advances only when op_cke=1):
- vp[0]<=accept, id[0]<=winner; vp[k]<=vp[k-1], id[k]<=id[k-1].
- Outputs: m_valid=vp[LATENCY-1], m_id=id[LATENCY-1], m_data=op_m_data.
- Result of an accept at edge t appears after LATENCY op_cke-qualified edges.
- A bubble (vp=0) at the tail never stalls. Accept and output retire occur in the same cycle.
- A clear request returns the op unit's CLEAR_DATA tagged with the requester ID, like any other result.

Inflight counter:
- inflight += accept; inflight -= (m_valid && m_ready && cke); simultaneous events net to 0.
- busy = inflight != 0.
- Never exceeds LATENCY.

Freeze:
- cke=0: every register holds, no accepts.
- m_valid/m_data stay stable while stalled or frozen.
- m_ready sampled while cke=0 does not retire a result.

Test Plan:
- Single requester, xnor op, NUM_REQ=4, LATENCY=3: req1 data0=0x5a data1=0xa5 at edge 0 -> m_valid=1, m_data=0x00, m_id=1 after 3 edges; busy=1 from edge 0 until retire.
- All four requesters valid continuously, pointer=0 -> grants 0,1,2,3,0 on consecutive cycles; results emerge in the same ID order, 3 cycles later.
- Backpressure: m_ready=0 for 5 cycles while results are in flight -> op_cke=0, s_req_ready=0, m_data/m_id held. Release -> results 0xff, 0xfe, 0xff retire without loss or duplication; inflight returns to 0.
- cke=0 for 2 cycles mid-stream -> no state change. Output order and values match the cke=1 reference; latency extended by 2.
- req2 with s_req_clear=1 (CLEAR_DATA=123) -> m_data=123, m_id=2.
- reset_n pulsed low with 3 ops in flight -> m_valid=0 immediately (async), inflight=0. No stale result after release; a new request completes normally.
